// File: rtl/lsu_ctrl_if.sv
// Request / memory / response bundle for the load/store control stage.
// The slave modport is the stage itself; master is the surrounding execute/memory/writeback side.
interface lsu_ctrl_if #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [3:0]      req_wdt;
  logic            req_sext;
  logic [RD_W-1:0] req_rd;

  logic [XLEN-1:0] mem_raddr;
  logic [XLEN-1:0] mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ren;
  logic            mem_wen;
  logic [3:0]      wdt_op;
  logic [XLEN-1:0] mem_rdata;

  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_data;
  logic [RD_W-1:0] resp_rd;
  logic            resp_is_load;
  logic            resp_fault;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wdt, req_sext, req_rd,
    output req_ready,
    output mem_raddr, mem_waddr, mem_wdata, mem_ren, mem_wen, wdt_op,
    input  mem_rdata,
    output resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
    input  resp_ready
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wdt, req_sext, req_rd,
    input  req_ready,
    input  mem_raddr, mem_waddr, mem_wdata, mem_ren, mem_wen, wdt_op,
    output mem_rdata,
    input  resp_valid, resp_data, resp_rd, resp_is_load, resp_fault,
    output resp_ready
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control stage: sequences one memory access per request and extends load data.
// Optional misaligned-access check is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_ctrl #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.slave  bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t          state_q, state_d;
  logic            accept;
  logic            misalign;
  logic [XLEN-1:0] addr_q, wdata_q, resp_data_q, ext_data;
  logic [3:0]      wdt_q;
  logic            is_load_q, sext_q, fault_q;
  logic [RD_W-1:0] rd_q;

  // Both handshakes: a transfer happens on a rising edge where valid && ready are high;
  // valid never depends on ready, and the stage holds resp_* stable while resp_valid is high.
  assign accept = bus.req_valid && bus.req_ready;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = (bus.req_wdt[1] &&  bus.req_addr[0])   ||
                    (bus.req_wdt[2] && |bus.req_addr[1:0]) ||
                    (bus.req_wdt[3] && |bus.req_addr[2:0]);
`else
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_ren    = 1'b0;
    bus.mem_wen    = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) state_d = misalign ? RESP : ISSUE;
      end
      ISSUE: begin
        // Gating with rst_n keeps a reset cycle from committing a negedge write.
        bus.mem_ren = rst_n &&  is_load_q;
        bus.mem_wen = rst_n && !is_load_q;
        state_d     = is_load_q ? CAPTURE : RESP;
      end
      CAPTURE: state_d = RESP;
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory returns zero-extended data; only the sign fill is added here.
  always_comb begin
    ext_data = bus.mem_rdata;
    if (sext_q) begin
      case (wdt_q)
        4'b0001: ext_data = {{(XLEN-8){bus.mem_rdata[7]}},   bus.mem_rdata[7:0]};
        4'b0010: ext_data = {{(XLEN-16){bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
        4'b0100: ext_data = {{(XLEN-32){bus.mem_rdata[31]}}, bus.mem_rdata[31:0]};
        default: ext_data = bus.mem_rdata;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wdt_q       <= 4'b1000;
      is_load_q   <= 1'b0;
      sext_q      <= 1'b0;
      rd_q        <= '0;
      fault_q     <= 1'b0;
      resp_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q      <= bus.req_addr;
        wdata_q     <= bus.req_wdata;
        wdt_q       <= bus.req_wdt;
        is_load_q   <= !bus.req_wen;
        sext_q      <= bus.req_sext;
        rd_q        <= bus.req_rd;
        fault_q     <= misalign;
        resp_data_q <= '0;
      end
      if (state_q == CAPTURE) resp_data_q <= ext_data;
    end
  end

  assign bus.mem_raddr    = addr_q;
  assign bus.mem_waddr    = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.wdt_op       = wdt_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_rd      = rd_q;
  assign bus.resp_is_load = is_load_q;
  assign bus.resp_fault   = fault_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset/stall sequences, then random traffic
// against a byte-array reference memory. Honours LSU_MISALIGN_CHECK_EN like the design.
module tb_lsu_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  int         tests = 0;
  int         fails = 0;
  int         ren_cnt = 0;
  int         wen_cnt = 0;
  logic [63:0] acc_addr = '0;

  bit [7:0] phys_mem [bit [63:0]];
  bit [7:0] ref_mem  [bit [63:0]];

  lsu_ctrl_if #(.XLEN(64), .RD_W(5)) bus ();

  lsu_ctrl #(.XLEN(64), .RD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [3:0]  wdt;
    logic        sext;
    logic [4:0]  rd;
    logic [63:0] exp_data;
    int          exp_lat;
    logic        exp_fault;
  } vec_t;

  function automatic int nbytes(input logic [3:0] wdt);
    case (wdt)
      4'b0001: return 1;
      4'b0010: return 2;
      4'b0100: return 4;
      default: return 8;
    endcase
  endfunction

  function automatic logic [63:0] phys_read(input logic [63:0] a, input logic [3:0] wdt);
    logic [63:0] v = '0;
    for (int i = 0; i < nbytes(wdt); i++)
      if (phys_mem.exists(a + 64'(i))) v[8*i +: 8] = phys_mem[a + 64'(i)];
    return v;
  endfunction

  // Reference load result: little-endian byte assembly, then sign fill by arithmetic.
  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [3:0] wdt,
                                             input logic sext);
    logic [63:0] v = '0;
    int n = nbytes(wdt);
    for (int i = 0; i < n; i++)
      if (ref_mem.exists(a + 64'(i))) v = v + (64'(ref_mem[a + 64'(i)]) << (8*i));
    if (sext && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    return v;
  endfunction

  function automatic logic model_fault(input logic [63:0] a, input logic [3:0] wdt);
`ifdef LSU_MISALIGN_CHECK_EN
    return (a % 64'(nbytes(wdt))) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // Memory model: registered read, negedge write.
  always @(posedge clk)
    if (bus.mem_ren) bus.mem_rdata <= phys_read(bus.mem_raddr, bus.wdt_op);

  always @(negedge clk) begin
    if (bus.mem_wen) begin
      for (int i = 0; i < nbytes(bus.wdt_op); i++)
        phys_mem[bus.mem_waddr + 64'(i)] = bus.mem_wdata[8*i +: 8];
      wen_cnt++;
      acc_addr = bus.mem_waddr;
    end
    if (bus.mem_ren) begin
      ren_cnt++;
      acc_addr = bus.mem_raddr;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    chk({nm, "_req_ready"},  64'(bus.req_ready), 64'd1);
    chk({nm, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({nm, "_resp_data"},  bus.resp_data, 64'd0);
    chk({nm, "_resp_rd"},    64'(bus.resp_rd), 64'd0);
    chk({nm, "_is_load"},    64'(bus.resp_is_load), 64'd0);
    chk({nm, "_fault"},      64'(bus.resp_fault), 64'd0);
    chk({nm, "_mem_en"},     64'({bus.mem_ren, bus.mem_wen}), 64'd0);
    chk({nm, "_addr"},       bus.mem_raddr | bus.mem_waddr, 64'd0);
    chk({nm, "_wdata"},      bus.mem_wdata, 64'd0);
    chk({nm, "_wdt_op"},     64'(bus.wdt_op), 64'h8);
  endtask

  task automatic do_txn(input string nm, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [3:0] wdt, input logic sext,
                        input logic [4:0] rd, input int stall, input logic [63:0] exp_data,
                        input int exp_lat, input logic exp_fault);
    int lat = 0;
    logic [63:0] snap;
    @(negedge clk);
    chk({nm, "_req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_wdt = wdt; bus.req_sext = sext; bus.req_rd = rd;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    ren_cnt = 0; wen_cnt = 0; acc_addr = '0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      chk({nm, "_resp_timeout"}, 64'd1, 64'd0);
      return;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_data"},    bus.resp_data, exp_data);
    chk({nm, "_rd"},      64'(bus.resp_rd), 64'(rd));
    chk({nm, "_is_load"}, 64'(bus.resp_is_load), 64'(!wen));
    chk({nm, "_fault"},   64'(bus.resp_fault), 64'(exp_fault));
    snap = bus.resp_data;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({nm, "_stall_valid"}, 64'(bus.resp_valid), 64'd1);
      chk({nm, "_stall_data"},  bus.resp_data, snap);
      chk({nm, "_stall_ready"}, 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_post_ready"}, 64'(bus.req_ready), 64'd1);
    chk({nm, "_post_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({nm, "_ren_cnt"}, 64'(ren_cnt), 64'(!wen && !exp_fault));
    chk({nm, "_wen_cnt"}, 64'(wen_cnt), 64'(wen && !exp_fault));
    if (!exp_fault) chk({nm, "_acc_addr"}, acc_addr, addr);
    if (wen && !exp_fault)
      for (int i = 0; i < nbytes(wdt); i++) ref_mem[addr + 64'(i)] = wdata[8*i +: 8];
  endtask

  vec_t vecs[11];

  initial begin
    logic [3:0]  r_wdt;
    logic [63:0] r_addr, r_wdata, r_exp;
    logic        r_wen, r_sext, r_fault;
    int          r_lat;

    vecs[0]  = '{"st64",     1'b1, 64'h80000010, 64'h1122334455667788, 4'b1000, 1'b0, 5'd3,  64'h0, 2, 1'b0};
    vecs[1]  = '{"ld64",     1'b0, 64'h80000010, 64'h0,                4'b1000, 1'b0, 5'd4,  64'h1122334455667788, 3, 1'b0};
    vecs[2]  = '{"st32",     1'b1, 64'h80000004, 64'hDEAD_BEEF_8000_0001, 4'b0100, 1'b0, 5'd5, 64'h0, 2, 1'b0};
    vecs[3]  = '{"ld32_sx",  1'b0, 64'h80000004, 64'h0, 4'b0100, 1'b1, 5'd6,  64'hFFFF_FFFF_8000_0001, 3, 1'b0};
    vecs[4]  = '{"ld32_zx",  1'b0, 64'h80000004, 64'h0, 4'b0100, 1'b0, 5'd7,  64'h0000_0000_8000_0001, 3, 1'b0};
    vecs[5]  = '{"st8",      1'b1, 64'h80000020, 64'h7F, 4'b0001, 1'b0, 5'd8,  64'h0, 2, 1'b0};
    vecs[6]  = '{"ld8_sx7f", 1'b0, 64'h80000020, 64'h0,  4'b0001, 1'b1, 5'd9,  64'h7F, 3, 1'b0};
    vecs[7]  = '{"st16",     1'b1, 64'h80000022, 64'h8123, 4'b0010, 1'b0, 5'd10, 64'h0, 2, 1'b0};
    vecs[8]  = '{"ld16_sx",  1'b0, 64'h80000022, 64'h0, 4'b0010, 1'b1, 5'd11, 64'hFFFF_FFFF_FFFF_8123, 3, 1'b0};
    vecs[9]  = '{"ld8_sx81", 1'b0, 64'h80000023, 64'h0, 4'b0001, 1'b1, 5'd12, 64'hFFFF_FFFF_FFFF_FF81, 3, 1'b0};
`ifdef LSU_MISALIGN_CHECK_EN
    vecs[10] = '{"ld32_mis", 1'b0, 64'h80000002, 64'h0, 4'b0100, 1'b1, 5'd13, 64'h0, 1, 1'b1};
`else
    vecs[10] = '{"ld32_mis", 1'b0, 64'h80000002, 64'h0, 4'b0100, 1'b1, 5'd13, 64'h0000_0000_0001_0000, 3, 1'b0};
`endif

    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_wdt = 4'b1000; bus.req_sext = 1'b0; bus.req_rd = '0; bus.resp_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("reset");

    for (int i = 0; i < 11; i++)
      do_txn(vecs[i].name, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].wdt, vecs[i].sext,
             vecs[i].rd, 0, vecs[i].exp_data, vecs[i].exp_lat, vecs[i].exp_fault);

    // Writeback stalls five cycles before taking the load result.
    do_txn("ld_stall", 1'b0, 64'h80000004, 64'h0, 4'b0100, 1'b1, 5'd14, 5,
           64'hFFFF_FFFF_8000_0001, 3, 1'b0);

    // Reset asserted during a store's ISSUE cycle: no write, everything back to reset values.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_wen = 1'b1; bus.req_addr = 64'h80000030;
    bus.req_wdata = 64'hA5A5_5A5A_0F0F_F0F0; bus.req_wdt = 4'b1000; bus.req_rd = 5'd15;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    wen_cnt = 0;
    @(negedge clk);
    chk("rst_issue_mem_wen", 64'(bus.mem_wen), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_mid");
    chk("rst_wen_cnt", 64'(wen_cnt), 64'd0);
    do_txn("rst_readback", 1'b0, 64'h80000030, 64'h0, 4'b1000, 1'b0, 5'd16, 0, 64'h0, 3, 1'b0);

    for (int k = 0; k < 40; k++) begin
      r_wen   = 1'($urandom_range(0, 1));
      r_wdt   = 4'b0001 << $urandom_range(0, 3);
      r_sext  = 1'($urandom_range(0, 1));
      r_wdata = {$urandom, $urandom};
      r_addr  = 64'h80000040 + 64'($urandom_range(0, 31) * nbytes(r_wdt));
      if ($urandom_range(0, 7) == 0) r_addr = r_addr + 64'($urandom_range(1, 7));
      r_fault = model_fault(r_addr, r_wdt);
      r_lat   = r_fault ? 1 : (r_wen ? 2 : 3);
      r_exp   = (r_fault || r_wen) ? 64'h0 : model_load(r_addr, r_wdt, r_sext);
      do_txn($sformatf("rand%0d", k), r_wen, r_addr, r_wdata, r_wdt, r_sext,
             5'($urandom_range(0, 31)), $urandom_range(0, 3), r_exp, r_lat, r_fault);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
